icache: RTL

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 108 ++++++++++
 1 files changed

// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per frame.
// It has a two-state fill FSM and a memory-side read port. Hit and fill counters wrap.
module icache #(
  parameter int unsigned SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [SETS-1:0]    r_valid;
  logic [TAG_W-1:0]   r_tag  [SETS];
  logic [31:0]        r_data [SETS];
  logic [29:0]        r_miss_word;
  logic [31:0]        r_hit_count;
  logic [31:0]        r_miss_count;

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [IDX_W-1:0]   w_fill_idx;
  logic [TAG_W-1:0]   w_fill_tag;
  logic               w_hit;
  logic               w_miss;
  logic               w_fill_done;
  logic               w_unused_offset;

  assign w_idx           = imemaddr[IDX_W+1:2];
  assign w_tag           = imemaddr[31:IDX_W+2];
  assign w_fill_idx      = r_miss_word[IDX_W-1:0];
  assign w_fill_tag      = r_miss_word[29:IDX_W];
  assign w_unused_offset = ^imemaddr[1:0];

  // Flush masks both the hit and the miss in the same IDLE cycle.
  assign w_hit       = (r_state == IDLE) && imemREN && !flush &&
                       r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_miss      = (r_state == IDLE) && imemREN && !flush && !w_hit;
  assign w_fill_done = (r_state == FETCH) && !iwait && !flush;

  always_comb begin
    w_next   = r_state;
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    case (r_state)
      IDLE: begin
        ihit = w_hit;
        if (w_hit) imemload = r_data[w_idx];
        if (w_miss) w_next = FETCH;
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = {r_miss_word, 2'b00};
        if (flush || !iwait) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_valid      <= '0;
      r_miss_word  <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_miss) r_miss_word <= imemaddr[31:2];
      if (w_hit) r_hit_count <= r_hit_count + 32'd1;
      if (flush) begin
        r_valid <= '0;
      end else if (w_fill_done) begin
        r_valid[w_fill_idx] <= 1'b1;
        r_miss_count        <= r_miss_count + 32'd1;
      end
    end
  end

  // Tag/data arrays are not reset. Reset forces IDLE, so no write can occur while it is asserted.
  always_ff @(posedge CLK) begin
    if (w_fill_done) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= iload;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

endmodule
